mux_bus_arbiter: RTL



---
 rtl/mux_arb_pkg.sv | 34 +++
 rtl/mux_arb_timer.sv | 38 +++
 rtl/mux_bus_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester bus arbiter.
//   arb_state_t      : arbiter FSM states
//   DEF_*            : default values for HOLD_MIN / MAX_GRANT / TURN_CYCLES
//   TIMER_W          : width of the grant/turnaround counter
//   SEL_A / SEL_B    : mux select encodings
//   rr_pick()        : round-robin winner between the two requesters
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_t;

    localparam int DEF_HOLD_MIN    = 2;
    localparam int DEF_MAX_GRANT   = 16;
    localparam int DEF_TURN_CYCLES = 1;

    localparam int TIMER_W = 5;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // On a tie the requester that was not served last wins; otherwise the
    // single requester wins. last_b=1 means B was served most recently.
    function automatic logic rr_pick(input logic ra, input logic rb, input logic last_b);
        if (ra && rb) begin
            return last_b ? SEL_A : SEL_B;
        end
        return ra ? SEL_A : SEL_B;
    endfunction

endpackage

// File: rtl/mux_arb_timer.sv
// Saturating up-counter shared by the ACTIVE (grant) and TURN (turnaround)
// phases of the arbiter.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   clear    : synchronous clear, has priority over enable
//   enable   : count up by one per cycle until LIMIT is reached
//   count    : current value
//   at_limit : count == LIMIT; counting stops there (no wrap)
module mux_arb_timer #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT_C)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count    = count_reg;
    assign at_limit = (count_reg == LIMIT_C);

endmodule

// File: rtl/mux_bus_arbiter.sv
// Two-requester arbiter for a shared 8-bit bus driven through a 2:1 mux with
// an active-low output enable. Sequence per grant: IDLE -> SETUP (select
// settles, bus Hi-Z) -> ACTIVE (bus driven) -> TURN (bus Hi-Z) -> IDLE.
//   clk         : clock, all state changes on its rising edge
//   rst_n       : asynchronous active-low reset, release synchronised
//   req_a/req_b : requests from A / B
//   done_a/b    : owner releases the bus (only looked at while granted)
//   gnt_a/gnt_b : A / B owns the bus
//   select      : mux select, SEL_A=0 / SEL_B=1
//   out_control : mux output enable, active-low (1 = Hi-Z)
//   busy        : high in every state except IDLE
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MIN    = DEF_HOLD_MIN,
    parameter int MAX_GRANT   = DEF_MAX_GRANT,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic select,
    output logic out_control,
    output logic busy
);

    localparam logic [TIMER_W-1:0] HOLD_MIN_C  = TIMER_W'(HOLD_MIN);
    localparam logic [TIMER_W-1:0] TURN_LAST_C = TIMER_W'(TURN_CYCLES - 1);

    // Reset: assertion propagates asynchronously through the sync stage,
    // deassertion takes two clock edges.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_reg[1];

    arb_state_t         state_reg;
    logic               gnt_a_reg;
    logic               gnt_b_reg;
    logic               select_reg;
    logic               out_control_reg;
    logic               busy_reg;
    logic               last_b_reg;

    logic [TIMER_W-1:0] timer_count;
    logic               timer_at_limit;
    logic               timer_clear;
    logic               timer_enable;

    logic               owner_req;
    logic               owner_done;
    logic               other_req;
    logic               release_now;
    logic               turn_end;

    // select_reg identifies the current owner from SETUP through TURN.
    assign owner_req  = (select_reg == SEL_B) ? req_b  : req_a;
    assign owner_done = (select_reg == SEL_B) ? done_b : done_a;
    assign other_req  = (select_reg == SEL_B) ? req_a  : req_b;

    // Voluntary release needs HOLD_MIN elapsed ACTIVE cycles; forced revoke
    // happens once the timer has saturated and the other side is waiting.
    assign release_now = (state_reg == ST_ACTIVE) &&
                         (((timer_count >= HOLD_MIN_C) && (owner_done || !owner_req)) ||
                          (timer_at_limit && other_req));

    assign turn_end = (timer_count >= TURN_LAST_C);

    // One counter serves both phases: cleared entering ACTIVE and entering TURN.
    assign timer_clear  = (state_reg == ST_SETUP) || release_now;
    assign timer_enable = (state_reg == ST_ACTIVE) || (state_reg == ST_TURN);

    mux_arb_timer #(
        .WIDTH (TIMER_W),
        .LIMIT (MAX_GRANT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .count    (timer_count),
        .at_limit (timer_at_limit)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg       <= ST_IDLE;
            gnt_a_reg       <= 1'b0;
            gnt_b_reg       <= 1'b0;
            select_reg      <= SEL_A;
            out_control_reg <= 1'b1;
            busy_reg        <= 1'b0;
            last_b_reg      <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        select_reg <= rr_pick(req_a, req_b, last_b_reg);
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    out_control_reg <= 1'b0;
                    gnt_a_reg       <= (select_reg == SEL_A);
                    gnt_b_reg       <= (select_reg == SEL_B);
                    state_reg       <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (release_now) begin
                        gnt_a_reg       <= 1'b0;
                        gnt_b_reg       <= 1'b0;
                        out_control_reg <= 1'b1;
                        last_b_reg      <= (select_reg == SEL_B);
                        state_reg       <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (turn_end) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_a       = gnt_a_reg;
    assign gnt_b       = gnt_b_reg;
    assign select      = select_reg;
    assign out_control = out_control_reg;
    assign busy        = busy_reg;

endmodule
